bcd_scan_counter: RTL
=====================

BCD_SCAN_COUNTER -- requirements
Module: bcd_scan_counter

Interface
REQ-001 The block SHALL have parameter PRESCALE, default 50000: the number of clk cycles per count tick; it SHALL be 2 or greater.
REQ-002 The block SHALL have parameter SCAN_DIV, default 1000: the number of clk cycles per display digit slot; it SHALL be 2 or greater.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 The block SHALL have port clk, input, 1 bit: the system clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-006 The block SHALL have port en, input, 1 bit: count enable; the prescaler advances only while en=1.
REQ-007 The block SHALL have port up, input, 1 bit: count direction, 1 = up, 0 = down; it is sampled on each tick.
REQ-008 The block SHALL have port load, input, 1 bit: a one-cycle load strobe.
REQ-009 The block SHALL have port load_val, input, 8 bits: two BCD digits, [7:4] = tens, [3:0] = ones.
REQ-010 The block SHALL have ports w, x, y, z, outputs, 1 bit each: the selected digit in BCD, w = MSB; they drive the seven-segment decoder directly.
REQ-011 The block SHALL have port dig_sel, output, 2 bits: one-hot digit enable, 01 = ones, 10 = tens.
REQ-012 The block SHALL have port wrap, output, 1 bit: a one-cycle pulse on a 99->00 or 00->99 rollover.
REQ-013 The block SHALL have port load_err, output, 1 bit: a one-cycle pulse when a load is rejected.

Function
REQ-014 The prescaler SHALL count 0..PRESCALE-1 while en=1, hold its value while en=0, and assert an internal tick in the cycle where it is at PRESCALE-1 with en=1, wrapping to 0 in that cycle.
REQ-015 On a tick with up=1, ones SHALL increment; ones 9->0 SHALL carry into tens; a 99 count SHALL become 00 with wrap=1 in the following cycle.
REQ-016 On a tick with up=0, ones SHALL decrement; ones 0->9 SHALL borrow from tens; a 00 count SHALL become 99 with wrap=1 in the following cycle.
REQ-017 A load with both nibbles at 9 or below SHALL set the count to load_val and clear the prescaler to 0 on the next edge, taking priority over a simultaneous tick; that tick is discarded.
REQ-018 A load with either nibble above 9 SHALL leave the count and prescaler unchanged and pulse load_err for exactly one cycle; a tick in that same cycle SHALL proceed normally.
REQ-019 The count SHALL never hold a nibble value above 9.
REQ-020 The scan counter SHALL run 0..SCAN_DIV-1 continuously, independent of en and load, and dig_sel SHALL toggle between 01 and 10 on each scan wrap.
REQ-021 {w,x,y,z} and dig_sel SHALL be registered and change on the same edge.
REQ-022 {w,x,y,z} SHALL equal the digit named by the next dig_sel value, taken from the count held before that edge, giving one cycle of latency from a count change to the display.
REQ-023 wrap and load_err SHALL be registered and last exactly one cycle.

Reset
REQ-024 While rst=1 at an edge, the block SHALL set count=00, prescaler=0, scan=0, dig_sel=01, {w,x,y,z}=0000, wrap=0 and load_err=0.
REQ-025 rst SHALL override en, load and any pending tick in the same cycle, including a reset mid-count.

Structure
REQ-026 A shared package bcd_pkg SHALL hold the 4-bit BCD digit typedef, the constants BCD_MAX=9, DIG_ONES=2'b01 and DIG_TENS=2'b10, and a function that checks whether a nibble is valid BCD.
REQ-027 The block SHALL contain one sub-module, bcd_digit: a single BCD digit with inc/dec, carry/borrow out, and load, instantiated twice in a ripple connection.

Verification (bench uses PRESCALE=4, SCAN_DIV=2)
REQ-028 Apply rst for 2 cycles, then en=1 and up=1 for 40 cycles -> count reaches 10, wrap stays 0, and dig_sel alternates 01/10 every 2 cycles with {w,x,y,z} = 0000/0001 matching.
REQ-029 Load 8'h99, then up=1 and en=1 -> on the next tick the count becomes 00 and wrap pulses for one cycle; repeat with load 8'h00 and up=0 -> the count becomes 99 and wrap pulses for one cycle.
REQ-030 Apply load=1 with 8'h37 in the same cycle as a tick -> the count is 37, the prescaler is 0, and the next tick occurs 4 cycles later.
REQ-031 Load 8'h3A -> load_err pulses for one cycle and the count is unchanged; load 8'hF0 -> the same response.
REQ-032 Set en=0 for 10 cycles mid-prescale -> the count and prescaler are frozen, scanning continues, and counting resumes from the held prescaler value when en returns to 1.
REQ-033 Assert rst while the count is 56 and load=1 -> on the next cycle the count is 00, dig_sel=01, {w,x,y,z}=0000, and wrap and load_err are 0.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared BCD types, constants and helpers for the scan counter.
package bcd_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t       BCD_MAX  = 4'd9;
  localparam logic [1:0] DIG_ONES = 2'b01;
  localparam logic [1:0] DIG_TENS = 2'b10;

  // True when the nibble is a legal BCD digit (0..9).
  function automatic logic bcd_valid(input bcd_t n);
    return n <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single BCD digit: load, increment with carry out, decrement with borrow out.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  input  logic load,
  input  bcd_t load_val,
  output bcd_t val,
  output logic carry_c,
  output logic borrow_c
);

  bcd_t val_q;
  bcd_t val_d;

  // Next digit value; load wins, inc wins over dec, illegal loads are ignored.
  always_comb begin
    val_d = val_q;
    if (load) begin
      if (bcd_valid(load_val)) begin
        val_d = load_val;
      end
    end else if (inc) begin
      val_d = (val_q == BCD_MAX) ? 4'd0 : val_q + 4'd1;
    end else if (dec) begin
      val_d = (val_q == 4'd0) ? BCD_MAX : val_q - 4'd1;
    end
  end

  // Digit register.
  always_ff @(posedge clk) begin
    if (rst) begin
      val_q <= 4'd0;
    end else begin
      val_q <= val_d;
    end
  end

  assign val      = val_q;
  assign carry_c  = inc && !load && (val_q == BCD_MAX);
  assign borrow_c = dec && !inc && !load && (val_q == 4'd0);

endmodule

// File: rtl/bcd_scan_counter.sv
// Two-digit BCD up/down counter with prescaler, load and multiplexed display scan.
module bcd_scan_counter
  import bcd_pkg::*;
#(
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       w,
  output logic       x,
  output logic       y,
  output logic       z,
  output logic [1:0] dig_sel,
  output logic       wrap,
  output logic       load_err
);

  localparam int unsigned PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam int unsigned SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  if (PRESCALE < 2) begin : g_bad_prescale
    $error("PRESCALE must be 2 or greater");
  end
  if (SCAN_DIV < 2) begin : g_bad_scan_div
    $error("SCAN_DIV must be 2 or greater");
  end

  logic [PW-1:0] presc_q, presc_d;
  logic [SW-1:0] scan_q, scan_d;
  logic [1:0]    dig_sel_q, dig_sel_d;
  bcd_t          disp_q, disp_d;
  logic          wrap_q, wrap_d;
  logic          load_err_q, load_err_d;

  logic tick_c;
  logic load_ok_c;
  logic cnt_tick_c;
  logic scan_wrap_c;
  bcd_t ones_val, tens_val;
  logic ones_carry_c, ones_borrow_c;
  logic tens_carry_c, tens_borrow_c;

  assign tick_c      = en && (presc_q == PW'(PRESCALE - 1));
  assign load_ok_c   = load && bcd_valid(load_val[7:4]) && bcd_valid(load_val[3:0]);
  assign cnt_tick_c  = tick_c && !load_ok_c;
  assign scan_wrap_c = (scan_q == SW'(SCAN_DIV - 1));

  bcd_digit u_ones (
    .clk      (clk),
    .rst      (rst),
    .inc      (cnt_tick_c && up),
    .dec      (cnt_tick_c && !up),
    .load     (load_ok_c),
    .load_val (load_val[3:0]),
    .val      (ones_val),
    .carry_c  (ones_carry_c),
    .borrow_c (ones_borrow_c)
  );

  bcd_digit u_tens (
    .clk      (clk),
    .rst      (rst),
    .inc      (ones_carry_c),
    .dec      (ones_borrow_c),
    .load     (load_ok_c),
    .load_val (load_val[7:4]),
    .val      (tens_val),
    .carry_c  (tens_carry_c),
    .borrow_c (tens_borrow_c)
  );

  // Prescaler, scan, display and pulse next-state logic.
  always_comb begin
    presc_d    = presc_q;
    scan_d     = scan_q + SW'(1);
    dig_sel_d  = dig_sel_q;
    wrap_d     = tens_carry_c || tens_borrow_c;
    load_err_d = load && !load_ok_c;

    if (load_ok_c) begin
      presc_d = '0;
    end else if (en) begin
      presc_d = tick_c ? '0 : presc_q + PW'(1);
    end

    if (scan_wrap_c) begin
      scan_d    = '0;
      dig_sel_d = (dig_sel_q == DIG_ONES) ? DIG_TENS : DIG_ONES;
    end

    disp_d = (dig_sel_d == DIG_TENS) ? tens_val : ones_val;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q    <= '0;
      scan_q     <= '0;
      dig_sel_q  <= DIG_ONES;
      disp_q     <= 4'd0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      scan_q     <= scan_d;
      dig_sel_q  <= dig_sel_d;
      disp_q     <= disp_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign {w, x, y, z} = disp_q;
  assign dig_sel      = dig_sel_q;
  assign wrap         = wrap_q;
  assign load_err     = load_err_q;

endmodule
